// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped seven-segment display: register map,
// store-type encodings, CTRL bit positions and the active-low hex segment table.
package mmio_pkg;

    localparam logic [15:0] ADDR_DATA   = 16'hffec;
    localparam logic [15:0] ADDR_CTRL   = 16'hfff0;
    localparam logic [15:0] ADDR_STATUS = 16'hfff4;

    typedef enum logic [2:0] {
        MW_NONE = 3'b000,
        MW_SW   = 3'b001,
        MW_SH   = 3'b010,
        MW_SB   = 3'b100
    } mem_wr_e;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_DATA,
        REG_CTRL,
        REG_STATUS
    } reg_sel_e;

    localparam int unsigned CTRL_EN_BIT    = 0;
    localparam int unsigned CTRL_BLANK_LSB = 8;
    localparam int unsigned CTRL_BLANK_MSB = 15;

    // Segment order {g,f,e,d,c,b,a}, 0 = segment lit.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_decoder.sv
// Hex nibble to active-low seven-segment pattern.
module seg_decoder
    import mmio_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/mmio_display.sv
// Memory-mapped 8-digit seven-segment display: DATA/CTRL/STATUS registers on the
// CPU data bus and a registered, tear-free digit scanner driving AN/SEG.
module mmio_display
    import mmio_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = ADDR_DATA,
    parameter int unsigned SCAN_DIV  = 50000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] Ad,
    input  logic [31:0] WrData,
    input  logic [2:0]  MemWr,
    output logic [31:0] RData,
    output logic        Hit,
    output logic [7:0]  AN,
    output logic [6:0]  SEG
);

    localparam logic [13:0] WORD_DATA   = BASE_ADDR[15:2];
    localparam logic [13:0] WORD_CTRL   = 14'(BASE_ADDR[15:2] + 14'd1);
    localparam logic [13:0] WORD_STATUS = 14'(BASE_ADDR[15:2] + 14'd2);
    localparam logic [15:0] CNT_MAX     = 16'(SCAN_DIV - 1);

    logic [31:0] data_q, data_d;
    logic [31:0] shadow_q, shadow_d;
    logic        en_q, en_d;
    logic [7:0]  blank_q, blank_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  frame_q, frame_d;
    logic [7:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic [6:0]  seg_dec;
    reg_sel_e    reg_sel;

    seg_decoder u_seg_decoder (
        .nibble (shadow_q[{idx_q, 2'b00} +: 4]),
        .seg    (seg_dec)
    );

    always_comb begin
        reg_sel = REG_NONE;
        if (Ad[15:2] == WORD_DATA)        reg_sel = REG_DATA;
        else if (Ad[15:2] == WORD_CTRL)   reg_sel = REG_CTRL;
        else if (Ad[15:2] == WORD_STATUS) reg_sel = REG_STATUS;

        Hit = (reg_sel != REG_NONE);
        case (reg_sel)
            REG_DATA:   RData = data_q;
            REG_CTRL:   RData = {16'b0, blank_q, 7'b0, en_q};
            REG_STATUS: RData = {16'b0, frame_q, 5'b0, idx_q};
            default:    RData = '0;
        endcase
    end

    // Big-endian lanes: byte offset 0 is bits 31:24.
    always_comb begin
        data_d  = data_q;
        en_d    = en_q;
        blank_d = blank_q;
        if (reg_sel == REG_DATA) begin
            if (MemWr == MW_SW && Ad[1:0] == 2'b00) begin
                data_d = WrData;
            end else if (MemWr == MW_SH && !Ad[0]) begin
                if (Ad[1]) data_d[15:0]  = WrData[15:0];
                else       data_d[31:16] = WrData[15:0];
            end else if (MemWr == MW_SB) begin
                case (Ad[1:0])
                    2'd0:    data_d[31:24] = WrData[7:0];
                    2'd1:    data_d[23:16] = WrData[7:0];
                    2'd2:    data_d[15:8]  = WrData[7:0];
                    default: data_d[7:0]   = WrData[7:0];
                endcase
            end
        end else if (reg_sel == REG_CTRL && MemWr == MW_SW && Ad[1:0] == 2'b00) begin
            en_d    = WrData[CTRL_EN_BIT];
            blank_d = WrData[CTRL_BLANK_MSB:CTRL_BLANK_LSB];
        end
    end

    // Shadow latches the pre-store DATA on the 7->0 wrap so a frame never tears.
    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        frame_d  = frame_q;
        shadow_d = shadow_q;
        an_d     = '1;
        seg_d    = '1;
        if (en_q) begin
            an_d  = ~(8'd1 << idx_q) | blank_q;
            seg_d = seg_dec;
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    shadow_d = data_q;
                    frame_d  = frame_q + 8'd1;
                end
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            data_q   <= '0;
            shadow_q <= '0;
            en_q     <= 1'b1;
            blank_q  <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            frame_q  <= '0;
            an_q     <= '1;
            seg_q    <= '1;
        end else begin
            data_q   <= data_d;
            shadow_q <= shadow_d;
            en_q     <= en_d;
            blank_q  <= blank_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign AN  = an_q;
    assign SEG = seg_q;

endmodule

// File: tb/tb_mmio_display.sv
// Directed bench for mmio_display with SCAN_DIV=4 (one digit per 4 clocks, 32-clock frame).
module tb_mmio_display;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] Ad = '0;
    logic [31:0] WrData = '0;
    logic [2:0]  MemWr = '0;
    logic [31:0] RData;
    logic        Hit;
    logic [7:0]  AN;
    logic [6:0]  SEG;

    int total = 0;
    int bad = 0;

    logic [6:0] seg_ref [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    mmio_display #(.BASE_ADDR(16'hffec), .SCAN_DIV(4)) dut (
        .Clk(Clk), .Reset(Reset), .Ad(Ad), .WrData(WrData), .MemWr(MemWr),
        .RData(RData), .Hit(Hit), .AN(AN), .SEG(SEG)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic store(input logic [15:0] a, input logic [31:0] d, input logic [2:0] mw);
        Ad = a; WrData = d; MemWr = mw;
        tick();
        MemWr = 3'b000; WrData = '0;
    endtask

    // Returns with the wrap edge just taken: idx=0, cnt=0.
    task automatic wait_wrap();
        logic [7:0] f0;
        bit seen;
        Ad = 16'hfff4; MemWr = 3'b000;
        #0;
        f0 = RData[15:8];
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (RData[15:8] != f0) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL wait_wrap: frame stuck at %0d, required a change within 40 cycles", f0);
        end
    endtask

    function automatic logic [6:0] digit_seg(input logic [31:0] v, input int d);
        logic [3:0] n;
        n = v[4*d +: 4];
        return seg_ref[n];
    endfunction

    // Checks the 32 cycles following a wrap edge.
    task automatic check_frame(input string tag, input logic [31:0] shown, input logic [7:0] blank);
        logic [7:0] exp_an;
        logic [2:0] exp_idx;
        int d;
        Ad = 16'hfff4;
        for (int k = 0; k < 32; k++) begin
            tick();
            d = k / 4;
            exp_an = ~(8'd1 << d) | blank;
            exp_idx = 3'(((k + 1) / 4) % 8);
            total++;
            if (AN !== exp_an) begin
                bad++;
                $display("FAIL %s AN k=%0d: got %h exp %h", tag, k, AN, exp_an);
            end
            total++;
            if (SEG !== digit_seg(shown, d)) begin
                bad++;
                $display("FAIL %s SEG k=%0d: got %h exp %h", tag, k, SEG, digit_seg(shown, d));
            end
            total++;
            if (RData[2:0] !== exp_idx) begin
                bad++;
                $display("FAIL %s STATUS.idx k=%0d: got %0d exp %0d", tag, k, RData[2:0], exp_idx);
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) tick();
        total++; if (AN !== 8'hFF) begin bad++; $display("FAIL reset AN: got %h exp ff", AN); end
        total++; if (SEG !== 7'h7F) begin bad++; $display("FAIL reset SEG: got %h exp 7f", SEG); end
        Ad = 16'hffec; #1;
        total++; if (RData !== 32'h0 || Hit !== 1'b1) begin bad++; $display("FAIL reset DATA: got %h hit %b exp 0 hit 1", RData, Hit); end
        Ad = 16'hfff0; #1;
        total++; if (RData !== 32'h1) begin bad++; $display("FAIL reset CTRL: got %h exp 1", RData); end
        Ad = 16'hfff4; #1;
        total++; if (RData !== 32'h0) begin bad++; $display("FAIL reset STATUS: got %h exp 0", RData); end
        Reset = 1'b0;
        tick();
        total++; if (AN !== 8'hFE) begin bad++; $display("FAIL first AN: got %h exp fe", AN); end
        total++; if (SEG !== 7'h40) begin bad++; $display("FAIL first SEG: got %h exp 40", SEG); end
    endtask

    task automatic test_scan();
        store(16'hffec, 32'h1234_5678, 3'b001);
        wait_wrap();
        check_frame("scan", 32'h1234_5678, 8'h00);
        Ad = 16'hffec; #1;
        total++; if (RData !== 32'h1234_5678) begin bad++; $display("FAIL lw DATA: got %h exp 12345678", RData); end
        total++; if (Hit !== 1'b1) begin bad++; $display("FAIL lw Hit: got %b exp 1", Hit); end
    endtask

    task automatic test_partial_stores();
        store(16'hffec, 32'h0, 3'b001);
        Ad = 16'hffed; WrData = 32'h0000_00AB; MemWr = 3'b100; #1;
        total++; if (RData !== 32'h0) begin bad++; $display("FAIL same-cycle read: got %h exp 0", RData); end
        tick();
        MemWr = 3'b000;
        total++; if (RData !== 32'h00AB_0000) begin bad++; $display("FAIL sb ffed: got %h exp 00ab0000", RData); end
        store(16'hffee, 32'h0000_C0DE, 3'b010);
        total++; if (RData !== 32'h00AB_C0DE) begin bad++; $display("FAIL sh ffee: got %h exp 00abc0de", RData); end
        store(16'hffed, 32'h0000_1111, 3'b010);
        total++; if (RData !== 32'h00AB_C0DE) begin bad++; $display("FAIL misaligned sh: got %h exp 00abc0de", RData); end
        store(16'hffee, 32'hFFFF_FFFF, 3'b001);
        total++; if (RData !== 32'h00AB_C0DE) begin bad++; $display("FAIL misaligned sw: got %h exp 00abc0de", RData); end
        store(16'hffec, 32'hDEAD_BEEF, 3'b011);
        total++; if (RData !== 32'h00AB_C0DE) begin bad++; $display("FAIL invalid MemWr: got %h exp 00abc0de", RData); end
        store(16'hfff0, 32'h0, 3'b010);
        total++; if (RData !== 32'h1) begin bad++; $display("FAIL sh CTRL: got %h exp 1", RData); end
        store(16'hfff3, 32'h0, 3'b100);
        total++; if (RData !== 32'h1) begin bad++; $display("FAIL sb CTRL: got %h exp 1", RData); end
    endtask

    task automatic test_blank();
        store(16'hfff0, 32'hFFFF_0F01, 3'b001);
        total++; if (RData !== 32'h0000_0F01) begin bad++; $display("FAIL CTRL readback: got %h exp 00000f01", RData); end
        wait_wrap();
        check_frame("blank", 32'h00AB_C0DE, 8'h0F);
        store(16'hfff0, 32'h1, 3'b001);
    endtask

    task automatic test_disable();
        logic [7:0] f;
        wait_wrap();
        repeat (20) tick();
        total++; if (RData[2:0] !== 3'd5) begin bad++; $display("FAIL pre-disable idx: got %0d exp 5", RData[2:0]); end
        store(16'hfff0, 32'h0, 3'b001);
        total++; if (AN !== 8'hDF) begin bad++; $display("FAIL disable-edge AN: got %h exp df", AN); end
        tick();
        total++; if (AN !== 8'hFF || SEG !== 7'h7F) begin bad++; $display("FAIL disabled AN/SEG: got %h/%h exp ff/7f", AN, SEG); end
        Ad = 16'hfff4; #1;
        f = RData[15:8];
        repeat (8) begin
            tick();
            total++;
            if (RData[2:0] !== 3'd5 || RData[15:8] !== f || AN !== 8'hFF) begin
                bad++;
                $display("FAIL hold: idx %0d frame %0d AN %h exp idx 5 frame %0d AN ff", RData[2:0], RData[15:8], AN, f);
            end
        end
        store(16'hfff0, 32'h1, 3'b001);
        total++; if (AN !== 8'hFF) begin bad++; $display("FAIL enable-edge AN: got %h exp ff", AN); end
        Ad = 16'hfff4;
        tick();
        total++; if (AN !== 8'hDF || SEG !== 7'h08) begin bad++; $display("FAIL resume AN/SEG: got %h/%h exp df/08", AN, SEG); end
        total++; if (RData[2:0] !== 3'd5) begin bad++; $display("FAIL resume idx: got %0d exp 5", RData[2:0]); end
        repeat (2) tick();
        total++; if (RData[2:0] !== 3'd6) begin bad++; $display("FAIL resume advance idx: got %0d exp 6", RData[2:0]); end
    endtask

    task automatic test_wrap_store();
        logic [7:0] f, prev;
        bit wrapped;
        wait_wrap();
        f = RData[15:8];
        repeat (31) tick();
        store(16'hffec, 32'hFFFF_FFFF, 3'b001);
        Ad = 16'hfff4; #1;
        total++; if (RData[15:8] !== 8'(f + 8'd1)) begin bad++; $display("FAIL wrap frame: got %0d exp %0d", RData[15:8], 8'(f + 8'd1)); end
        check_frame("old_frame", 32'h00AB_C0DE, 8'h00);
        check_frame("new_frame", 32'hFFFF_FFFF, 8'h00);
        wrapped = 0;
        for (int i = 0; i < 260 && !wrapped; i++) begin
            prev = RData[15:8];
            wait_wrap();
            total++;
            if (RData[15:8] !== 8'(prev + 8'd1)) begin
                bad++;
                $display("FAIL frame step: got %0d exp %0d", RData[15:8], 8'(prev + 8'd1));
            end
            if (prev == 8'd255) wrapped = 1;
        end
        total++; if (!wrapped || RData[15:8] !== 8'd0) begin bad++; $display("FAIL frame 255->0: got %0d exp 0", RData[15:8]); end
    endtask

    task automatic test_reset_midscan();
        wait_wrap();
        repeat (12) tick();
        total++; if (RData[2:0] !== 3'd3) begin bad++; $display("FAIL pre-reset idx: got %0d exp 3", RData[2:0]); end
        Reset = 1'b1;
        store(16'hffec, 32'h1234_5678, 3'b001);
        Reset = 1'b0;
        total++; if (AN !== 8'hFF || SEG !== 7'h7F) begin bad++; $display("FAIL midreset AN/SEG: got %h/%h exp ff/7f", AN, SEG); end
        Ad = 16'hffec; #1;
        total++; if (RData !== 32'h0) begin bad++; $display("FAIL midreset DATA: got %h exp 0", RData); end
        Ad = 16'hfff4; #1;
        total++; if (RData !== 32'h0) begin bad++; $display("FAIL midreset STATUS: got %h exp 0", RData); end
        Ad = 16'hfff0; #1;
        total++; if (RData !== 32'h1) begin bad++; $display("FAIL midreset CTRL: got %h exp 1", RData); end
        Ad = 16'h0000; #1;
        total++; if (Hit !== 1'b0 || RData !== 32'h0) begin bad++; $display("FAIL miss: hit %b data %h exp hit 0 data 0", Hit, RData); end
        tick();
        total++; if (AN !== 8'hFE || SEG !== 7'h40) begin bad++; $display("FAIL post-reset AN/SEG: got %h/%h exp fe/40", AN, SEG); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_partial_stores();
        test_blank();
        test_disable();
        test_wrap_store();
        test_reset_midscan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
